// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: write-port selectors, CTRL bit positions
// and the per-channel write-strobe decode.
package pwm_pkg;

  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_RSVD   = 2'd3
  } wr_sel_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_POL_BIT = 1;

  typedef struct packed {
    logic per;
    logic duty;
    logic ctrl;
  } wr_strb_t;

  function automatic wr_strb_t decode_wr(input logic hit, input logic [1:0] sel);
    wr_strb_t s;
    s = '0;
    if (hit) begin
      case (sel)
        SEL_PERIOD: s.per  = 1'b1;
        SEL_DUTY:   s.duty = 1'b1;
        SEL_CTRL:   s.ctrl = 1'b1;
        default:    s      = '0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active period and duty, enable/polarity, period counter and
// registered output/done flops. Active values only change at period boundaries.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             sync_i,
  input  wr_strb_t         wr_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             pwm_o,
  output logic             done_o
);

  logic [CNT_W-1:0] per_p_q, per_p_d, duty_p_q, duty_p_d;
  logic [CNT_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d, pol_q, pol_d;
  logic             pwm_q, pwm_d, done_q, done_d;
  logic             wrap_hit, load;

  assign wrap_hit = (cnt_q == per_a_q);
  // Disabled channels keep active tracking pending so enabling starts with fresh values.
  assign load     = (tick_i & en_q & wrap_hit) | ~en_q | sync_i;

  always_comb begin
    per_p_d  = wr_i.per  ? wr_data_i : per_p_q;
    duty_p_d = wr_i.duty ? wr_data_i : duty_p_q;
    en_d     = en_q;
    pol_d    = pol_q;
    if (wr_i.ctrl) begin
      en_d  = wr_data_i[CTRL_EN_BIT];
      pol_d = wr_data_i[CTRL_POL_BIT];
    end
    per_a_d  = load ? per_p_q  : per_a_q;
    duty_a_d = load ? duty_p_q : duty_a_q;

    cnt_d  = cnt_q;
    done_d = 1'b0;
    // Counting needs enable both before and after the edge: disable wins over a wrap,
    // and the enabling edge leaves the counter at 0 for a clean first period.
    if (!en_q || !en_d || sync_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (wrap_hit) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    pwm_d = (en_q & (cnt_q < duty_a_q)) ^ pol_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_p_q  <= '0;
      duty_p_q <= '0;
      per_a_q  <= '0;
      duty_a_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      pol_q    <= 1'b0;
      pwm_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      per_p_q  <= per_p_d;
      duty_p_q <= duty_p_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      pol_q    <= pol_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign done_o = done_q;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator: shared prescaler, write-port decode and one pwm_channel per output.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 16,
  parameter int unsigned CH_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_chan,
  input  logic [1:0]       wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [PSC_W-1:0] prescale,
  input  logic             sync_i,
  output logic [N_CH-1:0]  pwm_o,
  output logic [N_CH-1:0]  period_done_o
);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick;

  // A prescale lowered below the running count wraps through the full range; no special case.
  assign tick  = (psc_q == prescale) & ~sync_i;
  assign psc_d = (tick | sync_i) ? '0 : psc_q + PSC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wr_strb_t strb;
    // Channel numbers >= N_CH never match an instance, so such writes fall away.
    assign strb = decode_wr(wr_en && (wr_chan == CH_W'(i)), wr_sel);

    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .sync_i   (sync_i),
      .wr_i     (strb),
      .wr_data_i(wr_data),
      .pwm_o    (pwm_o[i]),
      .done_o   (period_done_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: expected per-cycle outputs are queued as stimulus is
// planned and compared one entry per clock.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned PSC_W = 16;
  localparam int unsigned CH_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [CH_W-1:0]  wr_chan;
  logic [1:0]       wr_sel;
  logic [CNT_W-1:0] wr_data;
  logic [PSC_W-1:0] prescale;
  logic             sync_i;
  logic [N_CH-1:0]  pwm_o;
  logic [N_CH-1:0]  period_done_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N_CH-1:0] pwm;
    logic [N_CH-1:0] done;
    logic [N_CH-1:0] pmask;
    int              m;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_multi #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .PSC_W(PSC_W),
    .CH_W (CH_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_chan      (wr_chan),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .prescale     (prescale),
    .sync_i       (sync_i),
    .pwm_o        (pwm_o),
    .period_done_o(period_done_o)
  );

  task automatic wr(input int chan, input logic [1:0] sel, input int data);
    wr_en   = 1'b1;
    wr_chan = CH_W'(chan);
    wr_sel  = sel;
    wr_data = CNT_W'(data);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic drive_wr(input int chan, input logic [1:0] sel, input int data);
    wr_en   = 1'b1;
    wr_chan = CH_W'(chan);
    wr_sel  = sel;
    wr_data = CNT_W'(data);
  endtask

  // Expected outputs m clocks after a restart (m=0 is the restart edge itself, where the
  // output still reflects the old counter). t = clocks per tick.
  task automatic push_pat(input int m_lo, input int m_hi, input int t, input int per,
                          input int duty, input bit pol, input bit en,
                          input logic [N_CH-1:0] chans);
    for (int m = m_lo; m <= m_hi; m++) begin
      exp_t e;
      e.m     = m;
      e.pwm   = '0;
      e.done  = '0;
      e.pmask = '1;
      for (int c = 0; c < N_CH; c++) begin
        if (chans[c]) begin
          if (m == 0) e.pmask[c] = 1'b0;
          else if (en) e.pwm[c] = ((((m - 1) / t) % (per + 1)) < duty) ^ pol;
          else e.pwm[c] = pol;
          e.done[c] = en && (m > 0) && ((m % (t * (per + 1))) == 0);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_sel = '0; wr_data = '0;
    prescale = '0; sync_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pwm_o !== '0) begin
      failures++; $display("FAIL reset_pwm got=%b want=%b", pwm_o, 8'h00);
    end
    checks++;
    if (period_done_o !== '0) begin
      failures++; $display("FAIL reset_done got=%b want=%b", period_done_o, 8'h00);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pwm_o !== '0 || period_done_o !== '0) begin
      failures++; $display("FAIL idle_after_reset pwm=%b done=%b want=0", pwm_o, period_done_o);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    wr(0, SEL_PERIOD, 9);
    wr(0, SEL_DUTY, 3);
    wr(0, SEL_CTRL, 1);
    push_pat(1, 30, 1, 9, 3, 1'b0, 1'b1, 8'h01);
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL basic_pwm m=%0d got=%b want=%b", e.m, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++; $display("FAIL basic_done m=%0d got=%b want=%b", e.m, period_done_o, e.done);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    push_pat(0, 100, 5, 9, 3, 1'b0, 1'b1, 8'h01);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin prescale = PSC_W'(4); sync_i = 1'b1; end
      @(posedge clk); #1; sync_i = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL psc_pwm m=%0d got=%b want=%b", e.m, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++; $display("FAIL psc_done m=%0d got=%b want=%b", e.m, period_done_o, e.done);
      end
    end
  endtask

  task automatic test_mid_update();
    exp_t e;
    push_pat(0, 10, 1, 9, 3, 1'b0, 1'b1, 8'h01);
    push_pat(11, 20, 1, 9, 7, 1'b0, 1'b1, 8'h01);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin prescale = '0; sync_i = 1'b1; end
      if (i == 3) drive_wr(0, SEL_DUTY, 7);
      @(posedge clk); #1; sync_i = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL update_pwm m=%0d got=%b want=%b", e.m, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++; $display("FAIL update_done m=%0d got=%b want=%b", e.m, period_done_o, e.done);
      end
    end
  endtask

  // Restart ch0 with sync after setting duty; covers both duty extremes.
  task automatic test_duty_edge(input int duty);
    exp_t e;
    wr(0, SEL_DUTY, duty);
    push_pat(0, 20, 1, 9, duty, 1'b0, 1'b1, 8'h01);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) sync_i = 1'b1;
      @(posedge clk); #1; sync_i = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL duty%0d_pwm m=%0d got=%b want=%b", duty, e.m, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++;
        $display("FAIL duty%0d_done m=%0d got=%b want=%b", duty, e.m, period_done_o, e.done);
      end
    end
  endtask

  task automatic test_polarity();
    exp_t e;
    push_pat(0, 20, 1, 9, 20, 1'b1, 1'b1, 8'h01);
    push_pat(0, 6, 1, 9, 20, 1'b1, 1'b0, 8'h01);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin sync_i = 1'b1; drive_wr(0, SEL_CTRL, 3); end
      if (i == 21) drive_wr(0, SEL_CTRL, 2);
      @(posedge clk); #1; sync_i = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL pol_pwm i=%0d got=%b want=%b", i, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++; $display("FAIL pol_done i=%0d got=%b want=%b", i, period_done_o, e.done);
      end
    end
  endtask

  task automatic test_sync();
    exp_t e;
    wr(0, SEL_DUTY, 3);
    wr(1, SEL_PERIOD, 9);
    wr(1, SEL_DUTY, 3);
    wr(0, SEL_CTRL, 1);
    repeat (3) begin @(posedge clk); #1; end
    wr(1, SEL_CTRL, 1);
    // Land the sync on the edge where ch0 would otherwise wrap.
    repeat (15) begin @(posedge clk); #1; end
    push_pat(0, 30, 1, 9, 3, 1'b0, 1'b1, 8'h03);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) sync_i = 1'b1;
      @(posedge clk); #1; sync_i = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((pwm_o & e.pmask) !== (e.pwm & e.pmask)) begin
        failures++; $display("FAIL sync_pwm m=%0d got=%b want=%b", e.m, pwm_o, e.pwm);
      end
      checks++;
      if (period_done_o !== e.done) begin
        failures++; $display("FAIL sync_done m=%0d got=%b want=%b", e.m, period_done_o, e.done);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [N_CH-1:0] want_hi;
    want_hi = 8'h03;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pwm_o !== want_hi) begin
      failures++; $display("FAIL pre_reset_pwm got=%b want=%b", pwm_o, want_hi);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_o !== '0 || period_done_o !== '0) begin
      failures++; $display("FAIL async_reset pwm=%b done=%b want=0", pwm_o, period_done_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_pat(1, 8, 1, 9, 0, 1'b0, 1'b0, '1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) drive_wr(N_CH, SEL_CTRL, 3);
      if (i == 1) drive_wr(15, SEL_CTRL, 3);
      @(posedge clk); #1; wr_en = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pwm_o !== e.pwm || period_done_o !== e.done) begin
        failures++;
        $display("FAIL bad_chan_write i=%0d pwm=%b done=%b want=%b/%b", i, pwm_o, period_done_o,
                 e.pwm, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_mid_update();
    test_duty_edge(0);
    test_duty_edge(20);
    test_polarity();
    test_sync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
